// File: rtl/e15_param_core_if.sv
// e15_param_core_if: run gate, program-load port and debug/status signals of the parameterised core.
interface e15_param_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
);
  localparam int INSTR_W = 8 + DATA_W;
  logic               run;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [1:0]         dbg_sel;
  logic [DATA_W-1:0]  dbg_data;
  logic [PC_W-1:0]    pc;
  logic               zflag;
  logic               cflag;
  logic               halted;
  modport master (
    output run, prog_we, prog_addr, prog_data, dbg_sel,
    input  dbg_data, pc, zflag, cflag, halted
  );
  modport slave (
    input  run, prog_we, prog_addr, prog_data, dbg_sel,
    output dbg_data, pc, zflag, cflag, halted
  );
endinterface

// File: rtl/e15_param_core.sv
// e15_param_core: four-register accumulator-style core with flags, relative jumps and a writable program memory.
module e15_param_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
) (
  input logic             clk,
  input logic             rst_n,
  e15_param_core_if.slave bus
);
  localparam int INSTR_W = 8 + DATA_W;
  localparam int DEPTH   = 2 ** PC_W;
  localparam logic [3:0] OP_JMP = 4'b0000;
  localparam logic [3:0] OP_HLT = 4'b0001;
  localparam logic [3:0] OP_JZ  = 4'b0010;
  localparam logic [3:0] OP_JNZ = 4'b0011;
  localparam logic [3:0] OP_JC  = 4'b0100;
  localparam logic [3:0] OP_JNC = 4'b0101;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0]  r [4];
  logic [PC_W-1:0]    pc, pc_next;
  logic               z, c, halted;
  logic [3:0]         op;
  logic [1:0]         src, dst;
  logic [DATA_W-1:0]  imm, a, b, res, wdata;
  logic               co, arith, sub, wr, taken, step;
  assign {op, src, dst, imm} = mem[pc];
  assign step = bus.run & ~halted;
  // 1010..1111 are the arithmetic group; bit 2 marks subtract-style, bit 0 the immediate form
  always_comb begin
    arith     = op[3] & (op[2] | op[1]);
    sub       = op[3] & op[2];
    a         = (arith & op[0]) ? imm : r[src];
    b         = r[dst];
    {co, res} = {1'b0, b} + {1'b0, sub ? ~a : a} + {{DATA_W{1'b0}}, sub};
    wr        = (arith & ~(op[2] & op[1])) | (op[3:1] == 3'b100);
    wdata     = arith ? res : op[0] ? imm : r[src];
    taken     = (op == OP_JMP) | (op == OP_JZ & z) | (op == OP_JNZ & ~z)
              | (op == OP_JC & c) | (op == OP_JNC & ~c);
    pc_next   = (op == OP_HLT) ? pc : taken ? pc + imm[PC_W-1:0] : pc + PC_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      halted <= 1'b0;
      r      <= '{default: '0};
    end else if (step) begin
      pc <= pc_next;
      if (arith) begin
        z <= (res == '0);
        c <= co;
      end
      if (wr) r[dst] <= wdata;
      if (op == OP_HLT) halted <= 1'b1;
    end
  end
  // program memory is outside the reset domain so a loaded program survives reset
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end
  assign bus.dbg_data = r[bus.dbg_sel];
  assign bus.pc       = pc;
  assign bus.zflag    = z;
  assign bus.cflag    = c;
  assign bus.halted   = halted;
endmodule

// File: tb/tb_e15_param_core.sv
// tb_e15_param_core: directed checks of the default core and a DATA_W=4, PC_W=3 instance.
module tb_e15_param_core;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  e15_param_core_if #(.DATA_W(8), .PC_W(4)) bus ();
  e15_param_core_if #(.DATA_W(4), .PC_W(3)) sbus ();
  e15_param_core #(.DATA_W(8), .PC_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  e15_param_core #(.DATA_W(4), .PC_W(3)) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));
  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] s, input logic [1:0] d, input logic [7:0] imm);
    return {op, s, d, imm};
  endfunction
  function automatic logic [11:0] sins(input logic [3:0] op, input logic [1:0] s, input logic [1:0] d, input logic [3:0] imm);
    return {op, s, d, imm};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [3:0] addr, input logic [15:0] data);
    bus.prog_we = 1'b1; bus.prog_addr = addr; bus.prog_data = data;
    step();
    bus.prog_we = 1'b0;
  endtask
  task automatic sload(input logic [2:0] addr, input logic [11:0] data);
    sbus.prog_we = 1'b1; sbus.prog_addr = addr; sbus.prog_data = data;
    step();
    sbus.prog_we = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [1:0] s, input logic [7:0] e);
    bus.dbg_sel = s;
    #1;
    chk(tag, bus.dbg_data, e);
  endtask
  task automatic srd(input string tag, input logic [1:0] s, input logic [3:0] e);
    sbus.dbg_sel = s;
    #1;
    chk(tag, sbus.dbg_data, e);
  endtask
  task automatic st(input string tag, input logic [3:0] p, input logic h, input logic zf, input logic cf);
    chk({tag, "_pc"}, bus.pc, p);
    chk({tag, "_halted"}, bus.halted, h);
    chk({tag, "_z"}, bus.zflag, zf);
    chk({tag, "_c"}, bus.cflag, cf);
  endtask
  task automatic sst(input string tag, input logic [2:0] p, input logic h, input logic zf, input logic cf);
    chk({tag, "_pc"}, sbus.pc, p);
    chk({tag, "_halted"}, sbus.halted, h);
    chk({tag, "_z"}, sbus.zflag, zf);
    chk({tag, "_c"}, sbus.cflag, cf);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.dbg_sel = '0;
    sbus.run = 1'b0; sbus.prog_we = 1'b0; sbus.prog_addr = '0; sbus.prog_data = '0; sbus.dbg_sel = '0;
    repeat (2) step();
    st("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rd("reset_reg", 2'(i), 8'h00);
    // loop program loaded while reset is held
    load(4'd0, ins(4'h9, 2'd0, 2'd0, 8'h05));
    load(4'd1, ins(4'hD, 2'd0, 2'd0, 8'h01));
    load(4'd2, ins(4'h3, 2'd0, 2'd0, 8'hFF));
    load(4'd3, ins(4'h1, 2'd0, 2'd0, 8'h00));
    rst_n = 1'b1; bus.run = 1'b1;
    repeat (3) step();
    chk("loop_first_jnz_pc", bus.pc, 4'd1);
    rd("loop_r0_4", 2'd0, 8'h04);
    repeat (9) step();
    st("loop_end", 4'd3, 1'b1, 1'b1, 1'b1);
    rd("loop_r0_0", 2'd0, 8'h00);
    repeat (10) step();
    st("halt_hold", 4'd3, 1'b1, 1'b1, 1'b1);
    rd("halt_hold_r0", 2'd0, 8'h00);
    // asynchronous reset pulse between edges
    #2 rst_n = 1'b0;
    #1 st("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("restart_pc", bus.pc, 4'd1);
    rd("restart_r0", 2'd0, 8'h05);
    // carry / compare program
    rst_n = 1'b0; bus.run = 1'b0;
    load(4'd0, ins(4'h9, 2'd0, 2'd1, 8'hFF));
    load(4'd1, ins(4'h9, 2'd0, 2'd2, 8'h01));
    load(4'd2, ins(4'hA, 2'd2, 2'd1, 8'h00));
    load(4'd3, ins(4'hB, 2'd0, 2'd1, 8'h01));
    load(4'd4, ins(4'h9, 2'd0, 2'd0, 8'h03));
    load(4'd5, ins(4'hF, 2'd0, 2'd0, 8'h03));
    load(4'd6, ins(4'hF, 2'd0, 2'd0, 8'h04));
    load(4'd7, ins(4'h4, 2'd0, 2'd0, 8'h05));
    load(4'd8, ins(4'h8, 2'd1, 2'd3, 8'h00));
    load(4'd9, ins(4'h1, 2'd0, 2'd0, 8'h00));
    rst_n = 1'b1; bus.run = 1'b1;
    repeat (3) step();
    st("add_carry", 4'd3, 1'b0, 1'b1, 1'b1);
    rd("add_carry_r1", 2'd1, 8'h00);
    step();
    st("addi", 4'd4, 1'b0, 1'b0, 1'b0);
    rd("addi_r1", 2'd1, 8'h01);
    repeat (2) step();
    st("cmpi_eq", 4'd6, 1'b0, 1'b1, 1'b1);
    rd("cmpi_eq_r0", 2'd0, 8'h03);
    step();
    st("cmpi_lt", 4'd7, 1'b0, 1'b0, 1'b0);
    rd("cmpi_lt_r0", 2'd0, 8'h03);
    step();
    chk("jc_not_taken_pc", bus.pc, 4'd8);
    step();
    st("mov", 4'd9, 1'b0, 1'b0, 1'b0);
    rd("mov_r3", 2'd3, 8'h01);
    bus.run = 1'b0;
    repeat (5) step();
    st("run_gate", 4'd9, 1'b0, 1'b0, 1'b0);
    rd("run_gate_r3", 2'd3, 8'h01);
    // overwrite the hlt at pc in the same edge it executes
    bus.run = 1'b1;
    load(4'd9, ins(4'h6, 2'd0, 2'd0, 8'h00));
    st("write_same_step", 4'd9, 1'b1, 1'b0, 1'b0);
    // sixteen nops wrap the pc
    rst_n = 1'b0; bus.run = 1'b0;
    for (int i = 0; i < 16; i++) load(4'(i), ins(4'h7, 2'd0, 2'd0, 8'h00));
    rst_n = 1'b1; bus.run = 1'b1;
    repeat (15) step();
    chk("wrap_pc15", bus.pc, 4'd15);
    step();
    st("wrap_pc0", 4'd0, 1'b0, 1'b0, 1'b0);
    bus.run = 1'b0;
    // narrow instance: loop program with truncated jnz offset
    rst_n = 1'b0;
    sload(3'd0, sins(4'h9, 2'd0, 2'd0, 4'h5));
    sload(3'd1, sins(4'hD, 2'd0, 2'd0, 4'h1));
    sload(3'd2, sins(4'h3, 2'd0, 2'd0, 4'hF));
    sload(3'd3, sins(4'h1, 2'd0, 2'd0, 4'h0));
    rst_n = 1'b1; sbus.run = 1'b1;
    repeat (12) step();
    sst("s_loop_end", 3'd3, 1'b1, 1'b1, 1'b1);
    srd("s_loop_r0", 2'd0, 4'h0);
    rst_n = 1'b0; sbus.run = 1'b0;
    sload(3'd0, sins(4'h9, 2'd0, 2'd1, 4'hF));
    sload(3'd1, sins(4'h9, 2'd0, 2'd2, 4'h1));
    sload(3'd2, sins(4'hA, 2'd2, 2'd1, 4'h0));
    sload(3'd3, sins(4'hB, 2'd0, 2'd1, 4'h1));
    rst_n = 1'b1; sbus.run = 1'b1;
    repeat (3) step();
    sst("s_add_carry", 3'd3, 1'b0, 1'b1, 1'b1);
    srd("s_add_carry_r1", 2'd1, 4'h0);
    step();
    sst("s_addi", 3'd4, 1'b0, 1'b0, 1'b0);
    srd("s_addi_r1", 2'd1, 4'h1);
    sbus.run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
